ser_framer: RTL

- Framing stage directly upstream of the serializer. Drives the serializer's load strobe and parallel word.
- Accepts payload words from a source over a valid/ready handshake and buffers them in a small FIFO.
- Emits one word every WIDTH enabled clocks: a SYNC word at the start of each frame, then FRAME_LEN payload slots.
- A payload slot with no buffered data is filled with IDLE_WORD, so frame length is fixed and the deserializer side can align on SYNC.

---
 rtl/ser_framer.sv | 116 +++++++++++
 1 files changed

// File: rtl/ser_framer.sv
// Framing stage ahead of the serializer: emits SYNC plus FRAME_LEN payload slots,
// one word every WIDTH enabled clocks, padding empty payload slots with IDLE_WORD.
module ser_framer #(
  parameter int              WIDTH      = 8,
  parameter int              FRAME_LEN  = 16,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hBC),
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'h1C)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               load,
  output logic [WIDTH-1:0]                   dout,
  output logic                               frame_start,
  output logic                               idle_ins,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(FRAME_LEN + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_SYNC, ST_PAYLOAD} state_t;

  state_t            state;
  logic [SW-1:0]     slot_cnt;
  logic [PW-1:0]     payload_cnt;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_next;
  logic              slot;
  logic              push;
  logic              pop;

  assign slot = enable && (slot_cnt == SW'(WIDTH - 1));
  assign push = in_valid && in_ready;
  // Pop decisions use the registered level, so a same-cycle push is never eligible.
  assign pop  = slot && (state == ST_PAYLOAD) && (fifo_level != '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + LW'(1);
    else if (pop && !push)
      level_next = fifo_level - LW'(1);
  end

  // NOTE: storage is deliberately left out of reset; the pointers and level alone say what is valid.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_SYNC;
      slot_cnt    <= '0;
      payload_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      in_ready    <= 1'b0;
      load        <= 1'b0;
      dout        <= '0;
      frame_start <= 1'b0;
      idle_ins    <= 1'b0;
    end else begin
      fifo_level  <= level_next;
      in_ready    <= (level_next < LW'(FIFO_DEPTH));
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      load        <= slot;
      frame_start <= 1'b0;
      idle_ins    <= 1'b0;

      if (enable)
        slot_cnt <= slot ? '0 : slot_cnt + SW'(1);

      if (slot) begin
        case (state)
          ST_SYNC: begin
            dout        <= SYNC_WORD;
            frame_start <= 1'b1;
            payload_cnt <= '0;
            state       <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            if (fifo_level != '0) begin
              dout <= mem[rd_ptr];
            end else begin
              dout     <= IDLE_WORD;
              idle_ins <= 1'b1;
            end
            // Idle slots count toward the frame, keeping the frame length fixed.
            if (payload_cnt == PW'(FRAME_LEN - 1))
              state <= ST_SYNC;
            else
              payload_cnt <= payload_cnt + PW'(1);
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule
